input_split_ctrl: RTL and testbench
===================================

INPUT_SPLIT_CTRL -- requirements
Module: input_split_ctrl

Interface
REQ-001 SHALL have parameter MASK, default 3'b001: destination-address bit mask that selects the out2 branch.
REQ-002 SHALL have parameter WIDTH_packet, default 14: packet width in bits. Packet[13:11] is the 3-bit destination address; packet[10:0] is the payload.
REQ-003 SHALL have parameter DEPTH, default 2: input buffer entries; legal values 2 or 4.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  WIDTH_packet  incoming packet.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block can accept a packet this cycle.
REQ-009 out1_data  output  WIDTH_packet  packet to branch 1.
REQ-010 out1_valid  output  1  out1_data is valid.
REQ-011 out1_ready  input  1  branch 1 accepts.
REQ-012 out2_data, out2_valid, out2_ready: same widths and meanings as the out1 signals, for branch 2.
REQ-013 cnt1, cnt2  output  8  count of packets delivered on out1 and out2.
REQ-014 busy  output  1  buffer is non-empty.

Function
REQ-015 SHALL accept a packet on any rising edge with in_valid=1 and in_ready=1 (input handshake), and SHALL write it to the FIFO tail.
REQ-016 SHALL drive in_ready = (occupancy < DEPTH), from registered state only, with no dependence on in_valid or either out ready.
REQ-017 SHALL NOT accept a packet when the FIFO is full, even if the head is popped in the same cycle.
REQ-018 SHALL compute the head route as sel = ((head[13:11] & MASK) != 0); sel=0 targets out1 and sel=1 targets out2.
REQ-019 SHALL assert out1_valid = !empty && !sel and out2_valid = !empty && sel. At most one of the two is high in any cycle.
REQ-020 SHALL drive out1_data and out2_data with the head entry. The value SHALL stay stable while that branch's valid=1 and ready=0.
REQ-021 SHALL pop the head on a rising edge where the selected branch has valid=1 and ready=1.
REQ-022 SHALL ignore the ready of the non-selected branch.
REQ-023 SHALL be strict FIFO with head-of-line blocking: a blocked head stalls all later packets, including those bound for the other branch.
REQ-024 Latency: a packet accepted at edge N into an empty FIFO SHALL appear on its output valid in the cycle after edge N. There is no combinational input-to-output path.
REQ-025 Throughput: SHALL sustain 1 packet per cycle when the target ready is held high. Simultaneous push and pop when not full SHALL leave occupancy unchanged.
REQ-026 With MASK=0, SHALL route every packet to out1.
REQ-027 With a multi-bit MASK, any overlapping bit set in the address SHALL select out2.
REQ-028 SHALL increment cnt1 or cnt2 by 1 on each pop to that branch, modulo 256 (255 wraps to 0).
REQ-029 SHALL implement read and write pointers modulo DEPTH, plus an occupancy counter 0..DEPTH. Pointer wrap SHALL NOT corrupt ordering.
REQ-030 SHALL set busy = (occupancy != 0).

Reset
REQ-031 While rst_n=0, SHALL asynchronously force the following outputs:
- in_ready=0
- out1_valid=0, out2_valid=0
- cnt1=0, cnt2=0
- busy=0
- occupancy and both pointers = 0
- out1_data and out2_data = 0
REQ-032 SHALL set in_ready=1 on the first rising edge after rst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all buffered packets without emitting them. An in-flight handshake in that cycle SHALL NOT take effect.

Verification
REQ-034 Reset, then send pkt 14'h0805 (addr 3'b001) with MASK=3'b001 and out2_ready=1 -> out2_valid high one cycle after acceptance, out2_data=14'h0805, out1_valid=0 throughout, cnt2=1, cnt1=0.
REQ-035 Send addr 3'b110, payload 11'h123, with MASK=3'b001 -> delivered on out1 with data 14'h3123, cnt1=1.
REQ-036 Hold out1_ready=0 and push 3 packets all bound for out1, DEPTH=2 -> in_ready=0 after 2 accepts and the third waits. Raising out1_ready -> packets emerge in order, 3 total, and in_ready returns to 1.
REQ-037 Head bound for out1 with out1_ready=0, second packet bound for out2 with out2_ready=1 -> out2_valid stays 0 until the head drains (head-of-line blocking).
REQ-038 Stream 257 packets to out2 back-to-back with out2_ready=1 -> one output per cycle after the first, cnt2 ends at 1 (wrap).
REQ-039 Fill the FIFO with 2 packets, then pulse rst_n low for half a cycle -> valids, busy, counters and in_ready drop immediately. After release no stale packet is emitted, and in_ready=1 after one edge.

Source files
------------

// File: rtl/input_split_ctrl_if.sv
// input_split_ctrl_if -- handshake bundle for the two-way packet splitter.
//   in_*    : upstream packet stream (valid/ready)
//   out1_*  : branch 1 packet stream (valid/ready)
//   out2_*  : branch 2 packet stream (valid/ready)
//   cnt1/2  : packets delivered per branch (mod 256)
//   busy    : splitter buffer holds at least one packet
// master = the environment (packet source / sinks), slave = the splitter.
interface input_split_ctrl_if #(
  parameter int WIDTH_packet = 14
);
  logic [WIDTH_packet-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH_packet-1:0] out1_data;
  logic                    out1_valid;
  logic                    out1_ready;
  logic [WIDTH_packet-1:0] out2_data;
  logic                    out2_valid;
  logic                    out2_ready;
  logic [7:0]              cnt1;
  logic [7:0]              cnt2;
  logic                    busy;

  modport master (
    output in_data, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid,
           cnt1, cnt2, busy
  );

  modport slave (
    input  in_data, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid,
           cnt1, cnt2, busy
  );
endinterface

// File: rtl/input_split_ctrl.sv
// input_split_ctrl -- buffers incoming packets in a small FIFO and steers the
// head packet to one of two branches based on its destination address.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of input_split_ctrl_if (in/out1/out2 handshakes,
//           per-branch delivery counters, busy flag)
// Routing: sel = |(addr & MASK); sel=0 -> out1, sel=1 -> out2. The FIFO is
// strictly ordered, so a stalled head blocks packets for either branch.
// DEPTH must be 2 or 4.
module input_split_ctrl #(
  parameter logic [2:0] MASK         = 3'b001,
  parameter int         WIDTH_packet = 14,
  parameter int         DEPTH        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input_split_ctrl_if.slave bus
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [2:0]              addr;
    logic [WIDTH_packet-4:0] payload;
  } pkt_t;

  // Run-enable FSM: input acceptance opens one edge after reset release, so
  // in_ready comes purely from flops and never from in_valid or out ready.
  typedef enum logic {ST_HOLD, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [OCC_W-1:0]        occ;
  logic [7:0]              cnt1_q, cnt2_q;

  pkt_t head;
  logic empty, sel, run;
  logic push, pop1, pop2, pop;
  logic v1, v2, rdy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  // ---- state register / next-state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HOLD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      ST_HOLD: state_nxt = ST_RUN;
      ST_RUN:  run       = 1'b1;
      default: state_nxt = ST_HOLD;
    endcase
  end

  // ---- head decode and handshakes ----
  assign head  = pkt_t'(mem[rd_ptr]);
  assign empty = (occ == '0);
  assign sel   = |(head.addr & MASK);
  assign v1    = !empty && !sel;
  assign v2    = !empty &&  sel;
  // Full blocks acceptance even if the head pops this same edge.
  assign rdy   = run && (occ < DEPTH_C);

  assign push = bus.in_valid && rdy;
  // Only the selected branch's ready can pop; the other is ignored.
  assign pop1 = v1 && bus.out1_ready;
  assign pop2 = v2 && bus.out2_ready;
  assign pop  = pop1 || pop2;

  // ---- storage ----
  // Entries are reset so both data outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---- delivery counters (natural 8-bit wrap) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      if (pop1) cnt1_q <= cnt1_q + 8'd1;
      if (pop2) cnt2_q <= cnt2_q + 8'd1;
    end
  end

  // ---- outputs ----
  assign bus.in_ready   = rdy;
  assign bus.out1_valid = v1;
  assign bus.out2_valid = v2;
  assign bus.out1_data  = mem[rd_ptr];
  assign bus.out2_data  = mem[rd_ptr];
  assign bus.cnt1       = cnt1_q;
  assign bus.cnt2       = cnt2_q;
  assign bus.busy       = !empty;

endmodule

// File: tb/tb_input_split_ctrl.sv
module tb_input_split_ctrl;
  localparam logic [2:0] MASK  = 3'b001;
  localparam int         W     = 14;
  localparam int         DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_split_ctrl_if #(.WIDTH_packet(W)) bus();

  input_split_ctrl #(.MASK(MASK), .WIDTH_packet(W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic         sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;
  logic [7:0] exp_cnt1 = 0;
  logic [7:0] exp_cnt2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic route(input logic [W-1:0] p);
    logic [2:0] a;
    a = p[W-1 -: 3];
    return (a & MASK) != 3'b000;
  endfunction

  // Scoreboard: every valid output cycle must match the queue head; a
  // handshake retires it.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot", 32'(bus.out1_valid & bus.out2_valid), 0);
      if (bus.out1_valid || bus.out2_valid) begin
        chk("q_has_entry", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("route", 32'(bus.out2_valid), 32'(q[0].sel));
          chk("data", 32'(bus.out2_valid ? bus.out2_data : bus.out1_data), 32'(q[0].data));
          if (bus.out1_valid && bus.out1_ready) begin
            void'(q.pop_front()); exp_cnt1++; delivered++;
          end else if (bus.out2_valid && bus.out2_ready) begin
            void'(q.pop_front()); exp_cnt2++; delivered++;
          end
        end
      end
    end
  end

  // Drives a packet and returns #1 after the accepting edge, in_valid left high.
  task automatic push(input logic [W-1:0] p);
    logic acc;
    acc = 1'b0;
    bus.in_data  = p;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back('{sel: route(p), data: p});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("push_accept", 32'(acc), 1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      @(posedge clk); #1;
      done = !bus.busy;
    end
    chk("drain", 32'(done), 1);
    @(posedge clk); #1;
    chk("q_empty", 32'(q.size()), 0);
    chk("cnt1", 32'(bus.cnt1), 32'(exp_cnt1));
    chk("cnt2", 32'(bus.cnt2), 32'(exp_cnt2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    exp_cnt1 = 0;
    exp_cnt2 = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_valid", 32'({bus.out1_valid, bus.out2_valid}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cnt", 32'({bus.cnt1, bus.cnt2}), 0);
    chk("rst_data", 32'({bus.out1_data, bus.out2_data}), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    time t0;
    int  d0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    do_reset();

    // addr 001 -> out2, visible the cycle after acceptance
    bus.out2_ready = 1'b1;
    push(14'h0805);
    bus.in_valid = 1'b0;
    chk("lat_out2_valid", 32'(bus.out2_valid), 1);
    chk("lat_out2_data", 32'(bus.out2_data), 32'h0805);
    chk("lat_out1_valid", 32'(bus.out1_valid), 0);
    drain();
    chk("t1_cnt2", 32'(bus.cnt2), 1);
    chk("t1_cnt1", 32'(bus.cnt1), 0);

    // addr 110 masked off -> out1
    bus.out1_ready = 1'b1;
    push(14'h3123);
    bus.in_valid = 1'b0;
    drain();
    chk("t2_cnt1", 32'(bus.cnt1), 1);

    // backpressure: full after 2, third waits
    bus.out1_ready = 1'b0;
    push(14'h0011);
    push(14'h0022);
    bus.in_data = 14'h0033;
    chk("full_in_ready", 32'(bus.in_ready), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("full_hold", 32'(bus.in_ready), 0);
    chk("full_busy", 32'(bus.busy), 1);
    d0 = delivered;
    bus.out1_ready = 1'b1;
    push(14'h0033);
    bus.in_valid = 1'b0;
    drain();
    chk("bp_delivered", 32'(delivered - d0), 3);
    chk("bp_in_ready", 32'(bus.in_ready), 1);

    // head-of-line blocking
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b1;
    push(14'h0044);
    push(14'h0955);
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("hol_out2_valid", 32'(bus.out2_valid), 0);
      chk("hol_out1_valid", 32'(bus.out1_valid), 1);
    end
    bus.out1_ready = 1'b1;
    drain();

    // 257 back-to-back to out2, counter wraps
    do_reset();
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b1;
    d0 = delivered;
    t0 = $time;
    for (int i = 0; i < 257; i++) push({3'b001, 11'(i * 7)});
    chk("stream_cycles", 32'(($time - t0) / 10), 257);
    bus.in_valid = 1'b0;
    chk("stream_busy", 32'(bus.busy), 1);
    drain();
    chk("stream_delivered", 32'(delivered - d0), 257);
    chk("stream_cnt2_wrap", 32'(bus.cnt2), 1);

    // half-cycle reset pulse with a full FIFO
    bus.out1_ready = 1'b0;
    push(14'h0101);
    push(14'h0202);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    exp_cnt1 = 0;
    exp_cnt2 = 0;
    #1;
    chk("pulse_in_ready", 32'(bus.in_ready), 0);
    chk("pulse_valid", 32'({bus.out1_valid, bus.out2_valid}), 0);
    chk("pulse_busy", 32'(bus.busy), 0);
    chk("pulse_cnt", 32'({bus.cnt1, bus.cnt2}), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pulse_rel_ready", 32'(bus.in_ready), 1);
    bus.out1_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_stale", 32'({bus.out1_valid, bus.out2_valid, bus.busy}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
